// File: rtl/memory_cell_ttl.sv
// Single cache entry: key/value storage, registered key-match lookup and TTL expiry
// paced by a tick prescaler. Optional sliding expiration via MEMORY_CELL_TTL_REFRESH_EN.
module memory_cell_ttl #(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32,
  parameter int TICK_DIV    = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write_op,
  input  logic                   delete_op,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic [TTL_WIDTH-1:0]   ttl_in,
  input  logic                   read_op,
  input  logic [KEY_WIDTH-1:0]   lookup_key,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [TTL_WIDTH-1:0]   ttl_out,
  output logic                   used_out,
  output logic                   hit_out,
  output logic                   expired_out
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PERSIST = 2'd1,
    TIMED   = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [PRESC_W-1:0]     presc_reg;
  logic [KEY_WIDTH-1:0]   key_reg, key_next;
  logic [VALUE_WIDTH-1:0] value_reg, value_next;
  logic [TTL_WIDTH-1:0]   ttl_reg, ttl_next;
  logic                   hit_reg, expired_reg;

  logic tick;
  logic wr_accept;
  logic del_req;
  logic expiring;
  logic match;
  logic refresh;
  logic [TTL_WIDTH-1:0] reload_val;

  assign tick      = (presc_reg == PRESC_LAST);
  assign wr_accept = write_op & (key_in != '0);
  // A write carrying the reserved empty key behaves exactly like a delete.
  assign del_req   = delete_op | (write_op & (key_in == '0));
  assign expiring  = (state_reg == TIMED) & tick & (ttl_reg == TTL_WIDTH'(1))
                   & ~write_op & ~delete_op;
  assign match     = read_op & (state_reg != FREE) & (lookup_key == key_reg)
                   & ~expiring & ~del_req;

`ifdef MEMORY_CELL_TTL_REFRESH_EN
  logic [TTL_WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_reg <= '0;
    end else if (wr_accept) begin
      reload_reg <= ttl_in;
    end
  end

  assign refresh    = match & (state_reg == TIMED);
  assign reload_val = reload_reg;
`else
  assign refresh    = 1'b0;
  assign reload_val = '0;
`endif

  // Prescaler free-runs; writes and deletes never disturb its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FREE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: write > delete > refresh > expiry
  always_comb begin
    state_next = state_reg;
    if (wr_accept) begin
      state_next = (ttl_in == '0) ? PERSIST : TIMED;
    end else if (del_req) begin
      state_next = FREE;
    end else if (refresh) begin
      state_next = state_reg;
    end else if (expiring) begin
      state_next = FREE;
    end
  end

  always_comb begin
    key_next   = key_reg;
    value_next = value_reg;
    ttl_next   = ttl_reg;
    if (wr_accept) begin
      key_next   = key_in;
      value_next = value_in;
      ttl_next   = ttl_in;
    end else if (del_req || expiring) begin
      key_next   = '0;
      value_next = '0;
      ttl_next   = '0;
    end else if (refresh) begin
      ttl_next   = reload_val;
    end else if ((state_reg == TIMED) && tick && (ttl_reg != '0)) begin
      ttl_next   = ttl_reg - TTL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg     <= '0;
      value_reg   <= '0;
      ttl_reg     <= '0;
      hit_reg     <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      key_reg     <= key_next;
      value_reg   <= value_next;
      ttl_reg     <= ttl_next;
      hit_reg     <= match;
      expired_reg <= expiring;
    end
  end

  // Output logic
  always_comb begin
    key_out     = key_reg;
    value_out   = value_reg;
    ttl_out     = ttl_reg;
    used_out    = (state_reg != FREE);
    hit_out     = hit_reg;
    expired_out = expired_reg;
  end

endmodule

// File: tb/tb_memory_cell_ttl.sv
// Randomised and directed bench for memory_cell_ttl: two instances (TICK_DIV=4 and 1)
// share stimulus and are compared every cycle against a behavioural entry model.
module tb_memory_cell_ttl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_op, delete_op, read_op;
  logic [7:0]  key_in, lookup_key;
  logic [63:0] value_in;
  logic [31:0] ttl_in;

  logic [7:0]  key_o   [2];
  logic [63:0] value_o [2];
  logic [31:0] ttl_o   [2];
  logic        used_o  [2];
  logic        hit_o   [2];
  logic        exp_o   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_cell_ttl #(.KEY_WIDTH(8), .VALUE_WIDTH(64), .TTL_WIDTH(32), .TICK_DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .write_op(write_op), .delete_op(delete_op),
    .key_in(key_in), .value_in(value_in), .ttl_in(ttl_in), .read_op(read_op),
    .lookup_key(lookup_key), .key_out(key_o[0]), .value_out(value_o[0]),
    .ttl_out(ttl_o[0]), .used_out(used_o[0]), .hit_out(hit_o[0]), .expired_out(exp_o[0])
  );

  memory_cell_ttl #(.KEY_WIDTH(8), .VALUE_WIDTH(64), .TTL_WIDTH(32), .TICK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .write_op(write_op), .delete_op(delete_op),
    .key_in(key_in), .value_in(value_in), .ttl_in(ttl_in), .read_op(read_op),
    .lookup_key(lookup_key), .key_out(key_o[1]), .value_out(value_o[1]),
    .ttl_out(ttl_o[1]), .used_out(used_o[1]), .hit_out(hit_o[1]), .expired_out(exp_o[1])
  );

  // Behavioural model of one entry per instance
  int          div_of [2];
  bit          m_used [2];
  logic [7:0]  m_key  [2];
  logic [63:0] m_val  [2];
  logic [31:0] m_ttl  [2];
  logic [31:0] m_rel  [2];
  int          m_cnt  [2];
  bit          m_hit  [2];
  bit          m_exp  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_used[i] = 0; m_key[i] = '0; m_val[i] = '0; m_ttl[i] = '0;
      m_rel[i] = '0; m_cnt[i] = 0; m_hit[i] = 0; m_exp[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit tick, is_wr, is_del, expiring, hit;
    tick     = (m_cnt[i] == div_of[i] - 1);
    is_wr    = write_op && (key_in != 0);
    is_del   = delete_op || (write_op && key_in == 0);
    expiring = m_used[i] && (m_ttl[i] == 1) && tick && !write_op && !delete_op;
    hit      = read_op && m_used[i] && (lookup_key == m_key[i]) && !expiring && !is_del;
    m_hit[i] = hit;
    m_exp[i] = expiring;
    if (is_wr) begin
      m_used[i] = 1; m_key[i] = key_in; m_val[i] = value_in; m_ttl[i] = ttl_in;
      m_rel[i] = ttl_in;
    end else if (is_del || expiring) begin
      m_used[i] = 0; m_key[i] = '0; m_val[i] = '0; m_ttl[i] = '0;
`ifdef MEMORY_CELL_TTL_REFRESH_EN
    end else if (hit && m_ttl[i] != 0) begin
      m_ttl[i] = m_rel[i];
`endif
    end else if (tick && m_ttl[i] != 0) begin
      m_ttl[i] = m_ttl[i] - 1;
    end
    m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s d%0d key", tag, i),   64'(key_o[i]),   64'(m_key[i]));
      check($sformatf("%s d%0d value", tag, i), value_o[i],      m_val[i]);
      check($sformatf("%s d%0d ttl", tag, i),   64'(ttl_o[i]),   64'(m_ttl[i]));
      check($sformatf("%s d%0d used", tag, i),  64'(used_o[i]),  64'(m_used[i]));
      check($sformatf("%s d%0d hit", tag, i),   64'(hit_o[i]),   64'(m_hit[i]));
      check($sformatf("%s d%0d expired", tag, i), 64'(exp_o[i]), 64'(m_exp[i]));
    end
  endtask

  task automatic set_idle();
    write_op = 0; delete_op = 0; read_op = 0;
    key_in = '0; lookup_key = '0; value_in = '0; ttl_in = '0;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_write(input string tag, input logic [7:0] k, input logic [63:0] v,
                          input logic [31:0] t);
    set_idle();
    write_op = 1; key_in = k; value_in = v; ttl_in = t;
    cycle(tag);
    set_idle();
  endtask

  task automatic do_read(input string tag, input logic [7:0] k);
    set_idle();
    read_op = 1; lookup_key = k;
    cycle(tag);
    set_idle();
  endtask

  task automatic do_delete(input string tag);
    set_idle();
    delete_op = 1;
    cycle(tag);
    set_idle();
  endtask

  task automatic idle(input string tag, input int n);
    set_idle();
    for (int c = 0; c < n; c++) cycle(tag);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    set_idle();
    #2 rst_n = 0;
    #1 model_reset();
    check_all({tag, " async"});
    @(negedge clk);
    check_all({tag, " held"});
    rst_n = 1;
  endtask

  initial begin
    int guard;
    div_of[0] = 4;
    div_of[1] = 1;
    set_idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1;

    // Expiry countdown
    do_write("exp_wr", 8'h12, 64'hDEADBEEF, 32'd3);
    idle("exp_run", 20);

    // Persistent entry
    do_write("pers_wr", 8'h34, 64'h1234, 32'd0);
    idle("pers_run", 10000);

    // Lookup hit / miss / after delete
    do_write("lk_wr", 8'h56, 64'hABCD, 32'd0);
    do_read("lk_hit", 8'h56);
    do_read("lk_miss", 8'h57);
    idle("lk_idle", 1);
    do_delete("lk_del");
    do_read("lk_after_del", 8'h56);
    do_delete("del_free");

    // Read alongside write sees pre-write contents
    do_write("rw_wr", 8'h21, 64'h1, 32'd0);
    set_idle();
    read_op = 1; lookup_key = 8'h21; write_op = 1; key_in = 8'h22; ttl_in = 32'd0;
    cycle("rw_same");
    do_read("rw_old", 8'h21);

    // Priority collisions in the expiring cycle
    do_write("col_wr1", 8'h78, 64'h5, 32'd1);
    do_write("col_over", 8'h78, 64'h6, 32'd4);
    idle("col_run", 2);
    do_write("col_wr2", 8'h78, 64'h7, 32'd1);
    do_delete("col_del");
    do_write("col_wr3", 8'h78, 64'h8, 32'd1);
    do_write("col_key0", 8'h00, 64'h9, 32'd3);
    do_write("col_wr4", 8'h78, 64'hA, 32'd1);
    do_read("col_read_exp", 8'h78);
    idle("col_idle", 8);

    // Sliding expiration (model follows the build configuration)
    do_write("ref_wr", 8'h44, 64'hBEEF, 32'd6);
    guard = 0;
    while (m_ttl[1] != 2 && guard < 20) begin
      idle("ref_wait", 1);
      guard++;
    end
    check("ref_reach_ttl2", 64'(ttl_o[1]), 64'd2);
    do_read("ref_hit", 8'h44);
    idle("ref_run", 40);

    // Reset mid-countdown
    do_write("rst_wr", 8'h12, 64'h55, 32'd5);
    idle("rst_pre", 2);
    async_reset("rst_mid");
    idle("rst_post", 6);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      write_op   = ($urandom_range(0, 9) == 0);
      delete_op  = ($urandom_range(0, 29) == 0);
      read_op    = ($urandom_range(0, 9) < 4);
      key_in     = 8'($urandom_range(0, 3));
      lookup_key = 8'($urandom_range(0, 3));
      value_in   = {$urandom, $urandom};
      ttl_in     = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
      cycle("rand");
      if ($urandom_range(0, 999) == 0) async_reset("rand_rst");
    end

    set_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
